ps2_key_encoder: RTL and testbench

- Converts the raw PS/2 set-2 scancode byte stream from the keyboard host link into the 11-bit `ps2_key` event word that core logic consumes.
- Word format: `[10]` toggle, `[9]` pressed, `[8]` extended, `[7:0]` code.
- Sits between the PS/2 byte deserializer and every core-side key decoder. It handles the E0/F0 prefix state, the E1 Pause sequence, keyboard housekeeping bytes and prefix timeouts.

---
 rtl/ps2_pkg.sv | 41 ++++
 rtl/ps2_prefix_timer.sv | 31 +++
 rtl/ps2_key_encoder.sv | 157 +++++++++++++++
 tb/tb_ps2_key_encoder.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 decoding definitions: FSM states, special byte codes,
// the Pause tail ROM and the ps2_key field positions.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT       = 8'hE0;
    localparam logic [7:0] PS2_BRK       = 8'hF0;
    localparam logic [7:0] PS2_PAUSE     = 8'hE1;

    localparam logic [7:0] PS2_ACK       = 8'hFA;
    localparam logic [7:0] PS2_BAT_OK    = 8'hAA;
    localparam logic [7:0] PS2_ECHO      = 8'hEE;
    localparam logic [7:0] PS2_RESEND    = 8'hFE;
    localparam logic [7:0] PS2_OVERRUN_0 = 8'h00;
    localparam logic [7:0] PS2_OVERRUN_1 = 8'hFF;

    // Bytes that follow E1 in the Pause make sequence, matched at index 1..7.
    localparam logic [7:0] PS2_PAUSE_TAIL [7] = '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    localparam logic [2:0] PAUSE_LAST = 3'd7;

    localparam int KEY_TOG = 10;
    localparam int KEY_PRS = 9;
    localparam int KEY_EXT = 8;

    function automatic logic is_housekeeping(input logic [7:0] b);
        return (b == PS2_ACK)    || (b == PS2_BAT_OK)    || (b == PS2_ECHO) ||
               (b == PS2_RESEND) || (b == PS2_OVERRUN_0) || (b == PS2_OVERRUN_1);
    endfunction

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_EXT) || (b == PS2_BRK) || (b == PS2_PAUSE);
    endfunction

endpackage

// File: rtl/ps2_prefix_timer.sv
// Loadable down-counter; expire is high while running with the count at zero.
module ps2_prefix_timer #(
    parameter int unsigned CYCLES = 24000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LOAD_VAL = W'(CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (load)
            cnt <= LOAD_VAL;
        else if (clear)
            cnt <= '0;
        else if (run && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expire = run & (cnt == '0);

endmodule

// File: rtl/ps2_key_encoder.sv
// Turns the PS/2 set-2 scancode byte stream into toggling 11-bit ps2_key events.
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | no prefix pending; plain bytes emit a make event
// EXT      | E0 seen
// BRK      | F0 seen
// EXT_BRK  | E0 F0 seen
// PAUSE    | E1 seen, matching the Pause tail at pause_idx
module ps2_key_encoder #(
    parameter int unsigned TIMEOUT_CYCLES    = 24000,
    parameter bit          FILTER_FAKE_SHIFT = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [10:0] ps2_key,
    output logic        key_strobe,
    output logic        seq_err
);
    import ps2_pkg::*;

    ps2_state_t  state, state_nxt;
    logic [2:0]  pause_idx, pause_idx_nxt;
    logic        acc, expire, hk, pre, fake, pause_hit;
    logic        emit, err;
    logic [9:0]  emit_word;

    assign acc       = in_valid & in_ready;
    assign hk        = is_housekeeping(in_data);
    assign pre       = is_prefix(in_data);
    assign fake      = FILTER_FAKE_SHIFT && (in_data == 8'h12 || in_data == 8'h59);
    assign pause_hit = (in_data == PS2_PAUSE_TAIL[pause_idx - 3'd1]);

    ps2_prefix_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (acc),
        .clear   (state == ST_IDLE),
        .run     (state != ST_IDLE),
        .expire  (expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            pause_idx <= '0;
        end else begin
            state     <= state_nxt;
            pause_idx <= pause_idx_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pause_idx_nxt = pause_idx;
        if (acc) begin
            case (state)
                ST_IDLE: begin
                    if (in_data == PS2_EXT)
                        state_nxt = ST_EXT;
                    else if (in_data == PS2_BRK)
                        state_nxt = ST_BRK;
                    else if (in_data == PS2_PAUSE) begin
                        state_nxt     = ST_PAUSE;
                        pause_idx_nxt = 3'd1;
                    end
                end
                ST_EXT:
                    state_nxt = (in_data == PS2_BRK) ? ST_EXT_BRK : ST_IDLE;
                ST_PAUSE: begin
                    if (pause_hit && pause_idx != PAUSE_LAST)
                        pause_idx_nxt = pause_idx + 3'd1;
                    else begin
                        state_nxt     = ST_IDLE;
                        pause_idx_nxt = '0;
                    end
                end
                default:
                    state_nxt = ST_IDLE;
            endcase
        end else if (expire) begin
            // A byte arriving on the expiry cycle wins, hence the else.
            state_nxt     = ST_IDLE;
            pause_idx_nxt = '0;
        end
    end

    always_comb begin
        emit      = 1'b0;
        err       = 1'b0;
        emit_word = '0;
        if (acc) begin
            case (state)
                ST_IDLE: begin
                    if (!hk && !pre) begin
                        emit      = 1'b1;
                        emit_word = {1'b1, 1'b0, in_data};
                    end
                end
                ST_EXT: begin
                    if (hk || in_data == PS2_EXT || in_data == PS2_PAUSE)
                        err = 1'b1;
                    else if (in_data != PS2_BRK && !fake) begin
                        emit      = 1'b1;
                        emit_word = {1'b1, 1'b1, in_data};
                    end
                end
                ST_BRK: begin
                    if (hk || pre)
                        err = 1'b1;
                    else begin
                        emit      = 1'b1;
                        emit_word = {1'b0, 1'b0, in_data};
                    end
                end
                ST_EXT_BRK: begin
                    if (hk || pre)
                        err = 1'b1;
                    else if (!fake) begin
                        emit      = 1'b1;
                        emit_word = {1'b0, 1'b1, in_data};
                    end
                end
                ST_PAUSE: begin
                    if (!pause_hit)
                        err = 1'b1;
                    else if (pause_idx == PAUSE_LAST) begin
                        emit      = 1'b1;
                        emit_word = {1'b1, 1'b1, 8'h77};
                    end
                end
                default: err = 1'b1;
            endcase
        end else if (expire) begin
            err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready   <= 1'b0;
            ps2_key    <= '0;
            key_strobe <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            in_ready   <= 1'b1;
            key_strobe <= emit;
            seq_err    <= err;
            if (emit)
                ps2_key <= {~ps2_key[KEY_TOG], emit_word[KEY_PRS], emit_word[KEY_EXT], emit_word[7:0]};
        end
    end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Randomized and directed checks of ps2_key_encoder against a byte-sequence model.
module tb_ps2_key_encoder;

    localparam int unsigned T = 24000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, key_strobe, seq_err;
    logic [10:0] ps2_key;
    logic        nf_ready, nf_strobe, nf_err;
    logic [10:0] nf_key;

    int n_checks = 0;
    int n_err    = 0;

    ps2_key_encoder #(.TIMEOUT_CYCLES(T), .FILTER_FAKE_SHIFT(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ps2_key(ps2_key), .key_strobe(key_strobe), .seq_err(seq_err)
    );

    ps2_key_encoder #(.TIMEOUT_CYCLES(T), .FILTER_FAKE_SHIFT(1'b0)) dut_nf (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(nf_ready), .ps2_key(nf_key), .key_strobe(nf_strobe), .seq_err(nf_err)
    );

    always #5 clk = ~clk;

    // Reference model: the pending prefix bytes are kept as a plain queue and
    // each new byte is classified against that history.
    logic [7:0]  pend[$];
    int unsigned idle_cnt;
    logic [10:0] m_key;
    logic        m_strobe, m_err;
    logic [7:0]  ptail [7] = '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    task automatic model_clear();
        pend.delete();
        idle_cnt = 0;
        m_key    = '0;
        m_strobe = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic model_emit(input logic prs, input logic ext, input logic [7:0] c);
        m_key    = {~m_key[10], prs, ext, c};
        m_strobe = 1'b1;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic hk, pre, ext, brk;
        hk  = (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
        pre = (b == 8'hE0) || (b == 8'hF0) || (b == 8'hE1);
        m_strobe = 1'b0;
        m_err    = 1'b0;
        idle_cnt = 0;
        if (pend.size() == 0) begin
            if (pre) pend.push_back(b);
            else if (!hk) model_emit(1'b1, 1'b0, b);
        end else if (pend[0] == 8'hE1) begin
            if (b == ptail[pend.size() - 1]) begin
                pend.push_back(b);
                if (pend.size() == 8) begin
                    model_emit(1'b1, 1'b1, 8'h77);
                    pend.delete();
                end
            end else begin
                m_err = 1'b1;
                pend.delete();
            end
        end else if (hk) begin
            m_err = 1'b1;
            pend.delete();
        end else if (b == 8'hF0 && pend.size() == 1 && pend[0] == 8'hE0) begin
            pend.push_back(b);
        end else if (pre) begin
            m_err = 1'b1;
            pend.delete();
        end else begin
            ext = (pend[0] == 8'hE0);
            brk = (pend[pend.size() - 1] == 8'hF0);
            if (!(ext && (b == 8'h12 || b == 8'h59)))
                model_emit(~brk, ext, b);
            pend.delete();
        end
    endtask

    task automatic model_idle();
        m_strobe = 1'b0;
        m_err    = 1'b0;
        if (pend.size() != 0) begin
            idle_cnt++;
            if (idle_cnt == T) begin
                m_err    = 1'b1;
                idle_cnt = 0;
                pend.delete();
            end
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        in_valid = v;
        in_data  = d;
        if (v) model_byte(d);
        else   model_idle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h1C;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, ps2_key, key_strobe, seq_err} !== 14'h0) begin
            n_err++;
            $display("FAIL reset_values: ready=%b key=%h strobe=%b err=%b want all 0", in_ready, ps2_key, key_strobe, seq_err);
        end
        in_valid = 1'b0;
        reset_n  = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || key_strobe !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready: ready=%b strobe=%b want ready=1 strobe=0", in_ready, key_strobe);
        end
    endtask

    task automatic test_basic();
        step(1'b1, 8'h1C);
        n_checks++;
        if (ps2_key !== 11'h61C || key_strobe !== 1'b1 || seq_err !== 1'b0) begin
            n_err++;
            $display("FAIL make_1c: key=%h strobe=%b err=%b want key=61c strobe=1 err=0", ps2_key, key_strobe, seq_err);
        end
        step(1'b0, 8'h00);
        n_checks++;
        if (key_strobe !== 1'b0) begin
            n_err++;
            $display("FAIL strobe_width: strobe=%b want 0", key_strobe);
        end
        step(1'b1, 8'hF0);
        n_checks++;
        if (key_strobe !== 1'b0 || seq_err !== 1'b0) begin
            n_err++;
            $display("FAIL break_prefix: strobe=%b err=%b want 0 0", key_strobe, seq_err);
        end
        step(1'b1, 8'h1C);
        n_checks++;
        if (ps2_key !== 11'h01C || key_strobe !== 1'b1) begin
            n_err++;
            $display("FAIL break_1c: key=%h strobe=%b want key=01c strobe=1", ps2_key, key_strobe);
        end
    endtask

    task automatic test_extended();
        logic [7:0] seq [5] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
        int strobes = 0, errs = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, seq[i]);
            strobes += int'(key_strobe);
            errs    += int'(seq_err);
            n_checks++;
            if ({ps2_key, key_strobe, seq_err} !== {m_key, m_strobe, m_err}) begin
                n_err++;
                $display("FAIL extended[%0d]: key=%h s=%b e=%b want key=%h s=%b e=%b", i, ps2_key, key_strobe, seq_err, m_key, m_strobe, m_err);
            end
        end
        n_checks++;
        if (strobes != 2 || errs != 0 || ps2_key !== 11'h175) begin
            n_err++;
            $display("FAIL extended_count: strobes=%0d errs=%0d key=%h want 2 0 175", strobes, errs, ps2_key);
        end
    endtask

    task automatic test_pause();
        logic [7:0] good [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        logic [7:0] bad  [5] = '{8'hE1, 8'h14, 8'h77, 8'h15, 8'h29};
        int strobes = 0, errs = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, good[i]);
            strobes += int'(key_strobe);
            errs    += int'(seq_err);
        end
        n_checks++;
        if (strobes != 1 || errs != 0 || ps2_key[9:0] !== 10'h377 || ps2_key !== m_key) begin
            n_err++;
            $display("FAIL pause_ok: strobes=%0d errs=%0d key=%h want 1 0 key=%h", strobes, errs, ps2_key, m_key);
        end
        strobes = 0;
        errs    = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, bad[i]);
            strobes += int'(key_strobe);
            errs    += int'(seq_err);
        end
        n_checks++;
        if (strobes != 0 || errs != 1 || seq_err !== 1'b1) begin
            n_err++;
            $display("FAIL pause_bad: strobes=%0d errs=%0d err_now=%b want 0 1 1", strobes, errs, seq_err);
        end
        step(1'b1, bad[4]);
        n_checks++;
        if (ps2_key[9:0] !== 10'h229 || key_strobe !== 1'b1 || ps2_key !== m_key) begin
            n_err++;
            $display("FAIL pause_after: key=%h strobe=%b want key=%h strobe=1", ps2_key, key_strobe, m_key);
        end
    endtask

    task automatic test_timeout();
        int errs = 0, early = 0, fired_at = -1;
        step(1'b1, 8'hE0);
        for (int i = 1; i <= int'(T) + 10; i++) begin
            step(1'b0, 8'h00);
            if (seq_err === 1'b1) begin
                errs++;
                if (fired_at < 0) fired_at = i;
            end
            if (i < int'(T) && seq_err === 1'b1) early++;
        end
        n_checks++;
        if (errs != 1 || early != 0 || fired_at != int'(T)) begin
            n_err++;
            $display("FAIL timeout: pulses=%0d early=%0d at=%0d want 1 0 %0d", errs, early, fired_at, T);
        end
        step(1'b1, 8'h29);
        n_checks++;
        if (ps2_key[9:0] !== 10'h229 || key_strobe !== 1'b1 || ps2_key !== m_key) begin
            n_err++;
            $display("FAIL timeout_next: key=%h strobe=%b want key=%h strobe=1", ps2_key, key_strobe, m_key);
        end
    endtask

    task automatic test_fake_shift();
        logic [7:0] seq [7] = '{8'hFA, 8'hAA, 8'hE0, 8'h12, 8'hE0, 8'hF0, 8'h59};
        int strobes = 0, errs = 0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(1'b1, seq[i]);
            strobes += int'(key_strobe);
            errs    += int'(seq_err) + int'(nf_err);
            if (i == 3) begin
                n_checks++;
                if (nf_key !== 11'h712 || nf_strobe !== 1'b1) begin
                    n_err++;
                    $display("FAIL nofilter_make: key=%h strobe=%b want 712 1", nf_key, nf_strobe);
                end
            end
        end
        n_checks++;
        if (strobes != 0 || errs != 0 || ps2_key !== 11'h000) begin
            n_err++;
            $display("FAIL fake_shift: strobes=%0d errs=%0d key=%h want 0 0 000", strobes, errs, ps2_key);
        end
        n_checks++;
        if (nf_key !== 11'h159 || nf_strobe !== 1'b1) begin
            n_err++;
            $display("FAIL nofilter_break: key=%h strobe=%b want 159 1", nf_key, nf_strobe);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        step(1'b1, 8'h29);
        step(1'b1, 8'hE0);
        step(1'b1, 8'hF0);
        reset_n = 1'b0;
        model_clear();
        for (int i = 0; i < 6; i++) begin
            in_valid = i[0];
            in_data  = 8'h75;
            @(posedge clk);
            #1;
            if ({in_ready, ps2_key, key_strobe, seq_err} !== 14'h0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL reset_mid: nonzero outputs in %0d cycles want 0", bad);
        end
        in_valid = 1'b0;
        reset_n  = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 8'h75);
        n_checks++;
        if (ps2_key !== 11'h675 || key_strobe !== 1'b1 || seq_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_next: key=%h strobe=%b err=%b want 675 1 0", ps2_key, key_strobe, seq_err);
        end
    endtask

    task automatic test_random();
        logic [7:0] hks [6] = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
        for (int n = 0; n < 400; n++) begin
            logic [7:0] q[$];
            logic [7:0] c;
            c = 8'($urandom_range(1, 8'h83));
            case ($urandom_range(0, 9))
                0: q = {c};
                1: q = {8'hF0, c};
                2: q = {8'hE0, c};
                3: q = {8'hE0, 8'hF0, c};
                4: q = {8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
                5: q = {hks[$urandom_range(0, 5)]};
                6: q = {8'hE0, ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59};
                7: q = {8'($urandom)};
                8: q = {8'hE0, 8'hE0};
                default: q = {8'hE1, 8'h14, 8'($urandom)};
            endcase
            foreach (q[j]) begin
                step(1'b1, q[j]);
                n_checks++;
                if ({ps2_key, key_strobe, seq_err} !== {m_key, m_strobe, m_err}) begin
                    n_err++;
                    $display("FAIL random[%0d]: byte=%h key=%h s=%b e=%b want key=%h s=%b e=%b", n, q[j], ps2_key, key_strobe, seq_err, m_key, m_strobe, m_err);
                end
            end
            repeat ($urandom_range(0, 2)) begin
                step(1'b0, 8'h00);
                n_checks++;
                if ({ps2_key, key_strobe, seq_err} !== {m_key, m_strobe, m_err}) begin
                    n_err++;
                    $display("FAIL random_gap[%0d]: key=%h s=%b e=%b want key=%h s=%b e=%b", n, ps2_key, key_strobe, seq_err, m_key, m_strobe, m_err);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extended();
        test_pause();
        test_timeout();
        test_fake_shift();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
